// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encodings and default parameters for the PISO serializer
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 4;

endpackage

// File: rtl/strobe_div.sv
// rtl/strobe_div.sv - bit-period divider producing a one-cycle terminal-count strobe
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - count enable (high while a bit period is running)
//   clr  - synchronous clear, restarts the bit period at 0
//   tc   - high for the cycle in which the count sits at CLK_DIV-1 while enabled
module strobe_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Returns to 0 after the terminal value so every bit period is exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TERM) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tc = en && (cnt == TERM);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter, MSB first, one strobe per bit
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit period after the data bits.
//
// Ports:
//   i_CLK    - system clock, rising edge
//   i_RST    - synchronous active-high reset
//   i_DATA   - word to transmit, captured on the valid/ready handshake
//   i_VALID  - i_DATA valid
//   o_READY  - word can be accepted this cycle (IDLE only)
//   o_SDO    - serial data, held for a full bit period
//   o_SFT    - one-cycle shift strobe at the end of each bit period
//   o_BUSY   - a word is being shifted out
//   o_DONE   - one-cycle pulse after the final strobe
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [DATA_W-1:0] i_DATA,
    input  logic              i_VALID,
    output logic              o_READY,
    output logic              o_SDO,
    output logic              o_SFT,
    output logic              o_BUSY,
    output logic              o_DONE
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              load;
    logic              div_en;
    logic              div_tc;
`ifdef PISO_PARITY_EN
    logic              parity_bit;
`endif

    assign load  = i_VALID && o_READY;
    assign o_SFT = div_tc;

    strobe_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk (i_CLK),
        .rst (i_RST),
        .en  (div_en),
        .clr (load),
        .tc  (div_tc)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_READY   = 1'b0;
        o_BUSY    = 1'b0;
        o_DONE    = 1'b0;
        div_en    = 1'b0;
        // The shift register MSB is the current bit; it drains to 0 by the end of a word.
        o_SDO     = shreg[DATA_W-1];
        case (state)
            ST_IDLE: begin
                o_READY = 1'b1;
                if (i_VALID) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_BUSY = 1'b1;
                div_en = 1'b1;
                if (div_tc && (bit_cnt == LAST_BIT)) begin
`ifdef PISO_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                o_BUSY = 1'b1;
                div_en = 1'b1;
                o_SDO  = parity_bit;
                if (div_tc) begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                o_DONE    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset has priority over a same-cycle handshake, so nothing is loaded then.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= i_DATA;
            bit_cnt <= '0;
        end else if ((state == ST_SHIFT) && div_tc) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            parity_bit <= 1'b0;
        end else if (load) begin
            parity_bit <= ^i_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer at CLK_DIV=4 and CLK_DIV=1
module tb_piso_serializer;

    localparam int DW = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] valid;
    logic [7:0] data [2];
    logic [1:0] ready, sdo, sft, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_W(8), .CLK_DIV(4)) u_dut0 (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_DATA  (data[0]),
        .i_VALID (valid[0]),
        .o_READY (ready[0]),
        .o_SDO   (sdo[0]),
        .o_SFT   (sft[0]),
        .o_BUSY  (busy[0]),
        .o_DONE  (done[0])
    );

    piso_serializer #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_DATA  (data[1]),
        .i_VALID (valid[1]),
        .o_READY (ready[1]),
        .o_SDO   (sdo[1]),
        .o_SFT   (sft[1]),
        .o_BUSY  (busy[1]),
        .o_DONE  (done[1])
    );

    function automatic int divof(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // k-th transmitted bit: data MSB first, then even parity of the word.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < DW) return w[DW-1-k];
        return ^w;
    endfunction

    // {sdo, sft, busy, done, ready}
    function automatic logic [4:0] outs(input int d);
        return {sdo[d], sft[d], busy[d], done[d], ready[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge in an idle cycle: presents the word for the coming edge.
    task automatic start_word(input int d, input logic [7:0] w);
        chk($sformatf("ready_before_%0d_%02h", d, w), {31'd0, ready[d]}, 32'd1);
        data[d]  = w;
        valid[d] = 1'b1;
    endtask

    // Follows a word from the handshake cycle (cycle 0) to the idle cycle after o_DONE.
    task automatic run_word(input int d, input logic [7:0] w, input bit hold, input logic [7:0] nxt);
        int         dv   = divof(d);
        int         last = NB * dv;
        int         nstb = 0;
        logic [7:0] sipo = 8'h00;
        logic       pbit = 1'b0;
        logic [4:0] e;
        @(negedge clk);
        if (hold) data[d] = nxt;
        else valid[d] = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            if (c <= last) e = {exp_bit(w, (c - 1) / dv), ((c % dv) == 0), 1'b1, 1'b0, 1'b0};
            else e = 5'b00010;
            chk($sformatf("d%0d_w%02h_c%0d", d, w, c), {27'd0, outs(d)}, {27'd0, e});
            if (sft[d] === 1'b1) begin
                nstb++;
                if (nstb <= DW) sipo = {sipo[6:0], sdo[d]};
                else pbit = sdo[d];
            end
            @(negedge clk);
        end
        chk($sformatf("d%0d_w%02h_idle", d, w), {27'd0, outs(d)}, 32'b00001);
        chk($sformatf("d%0d_w%02h_strobes", d, w), nstb, NB);
        chk($sformatf("d%0d_w%02h_sipo", d, w), {24'd0, sipo}, {24'd0, w});
        if (NB > DW) chk($sformatf("d%0d_w%02h_parity", d, w), {31'd0, pbit}, {31'd0, ^w});
    endtask

    initial begin
        int         cnt;
        logic       bad;
        int         d;
        logic [7:0] w;

        rst      = 1'b1;
        valid    = 2'b00;
        data[0]  = 8'h00;
        data[1]  = 8'h00;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_d0", {27'd0, outs(0)}, 32'b00001);
        chk("reset_d1", {27'd0, outs(1)}, 32'b00001);
        rst = 1'b0;
        @(negedge clk);
        chk("release_d0", {27'd0, outs(0)}, 32'b00001);
        chk("release_d1", {27'd0, outs(1)}, 32'b00001);

        // Basic word at CLK_DIV=4.
        start_word(0, 8'hA5);
        run_word(0, 8'hA5, 1'b0, 8'h00);

        // One bit per clock.
        start_word(1, 8'h3C);
        run_word(1, 8'h3C, 1'b0, 8'h00);

        // Back-to-back with valid held; data changes while busy must be ignored.
        start_word(0, 8'hFF);
        run_word(0, 8'hFF, 1'b1, 8'h01);
        run_word(0, 8'h01, 1'b0, 8'h00);

        // Reset after the third strobe of a word.
        start_word(0, 8'hC3);
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 3; c++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            if (sft[0] === 1'b1) cnt++;
        end
        chk("rst_mid_strobe_count", cnt, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_after_edge", {27'd0, outs(0)}, 32'b00001);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bad = bad | (sft[0] !== 1'b0) | (done[0] !== 1'b0) | (ready[0] !== 1'b1);
        end
        chk("rst_mid_quiet", {31'd0, bad}, 32'd0);
        start_word(0, 8'h81);
        run_word(0, 8'h81, 1'b0, 8'h00);

        // Reset and valid in the same cycle: nothing loaded.
        rst      = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 8'h5A;
        @(negedge clk);
        chk("rst_valid_same", {27'd0, outs(0)}, 32'b00001);
        rst      = 1'b0;
        valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_valid_after", {27'd0, outs(0)}, 32'b00001);

        // Randomized words on both instances with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(0, 1));
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_word(d, w);
            run_word(d, w, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
